cla_block_serial_adder: RTL and testbench
=========================================

CLA_BLOCK_SERIAL_ADDER -- requirements
Module: cla_block_serial_adder

Interface
REQ-001 The block SHALL have parameter N, default 16: operand and sum width in bits; N >= 2.
REQ-002 The block SHALL have parameter BLOCK, default 4: carry-look-ahead group width; N % BLOCK == 0 and BLOCK <= N; other values are unsupported. NB = N/BLOCK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and mode present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, N bits: operand A.
REQ-008 The block SHALL have port b, input, N bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (sub).
REQ-010 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin; 1 = A-B-cin.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The block SHALL have port sum, output, N bits: registered result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for sub, 1 = no borrow.
REQ-015 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port zero, output, 1 bit: sum == 0.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE with rst_n high; it is combinational from state.
REQ-019 In IDLE, in_valid & in_ready at a rising edge SHALL: capture a; capture b, or ~b when sub=1; set internal carry to cin ^ sub; clear block counter k; go to CALC.
REQ-020 In CALC, each edge SHALL process group k (bits k*BLOCK .. k*BLOCK+BLOCK-1):
- generate g = a&b, propagate p = a^b;
- group carries by look-ahead from the internal carry, not ripple;
- write the group's sum bits into the sum register;
- update the internal carry to the group carry-out;
- increment k.
REQ-021 On the edge processing group NB-1, the block SHALL:
- set cout = final carry;
- set overflow = carry into MSB XOR carry out of MSB;
- set zero = (complete N-bit sum == 0);
- go to DONE.
REQ-022 Latency SHALL be exactly NB+1 rising edges from the accepting edge to out_valid high (5 for N=16, BLOCK=4).
REQ-023 out_valid SHALL be 1 only in DONE.
REQ-024 In DONE, sum, cout, overflow and zero SHALL stay stable while out_ready = 0, for any number of cycles.
REQ-025 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE; no new operand is accepted on that same edge.
REQ-026 in_valid, a, b, cin and sub SHALL be ignored outside IDLE; operands captured at accept SHALL NOT be affected by later input changes.
REQ-027 sum and the flags SHALL hold the last result in IDLE until the next completion; they SHALL be updated only in CALC.
REQ-028 Intermediate sum bits MAY be visible during CALC; the consumer SHALL qualify sum and flags with out_valid.
REQ-029 NB == 1 SHALL work: CALC lasts one edge, latency 2.

Reset
REQ-030 rst_n low SHALL immediately, without a clock edge:
- force IDLE;
- clear k, the internal carry and the operand registers;
- set sum=0, cout=0, overflow=0, zero=0, out_valid=0, in_ready=0.
REQ-031 Reset asserted in CALC or DONE SHALL discard the in-flight operation; no out_valid pulse follows reset release.
REQ-032 After rst_n rises, in_ready SHALL be 1 and the first operation SHALL behave per REQ-019 to REQ-022.

Verification (N=16, BLOCK=4)
REQ-033 Add 0x00FF + 0x0001, cin=0 -> sum 0x0100, cout 0, overflow 0, zero 0; out_valid exactly 5 edges after accept.
REQ-034 Add 0xFFFF + 0x0001, cin=0 -> sum 0x0000, cout 1, overflow 0, zero 1 (carry crosses all 4 groups).
REQ-035 Sub 0x8000 - 0x0001, cin=0 -> sum 0x7FFF, cout 1, overflow 1; add 0x7FFF + 0x0001 -> sum 0x8000, cout 0, overflow 1.
REQ-036 Sub 0x0003 - 0x0005, cin=1 -> sum 0xFFFD, cout 0 (borrow), overflow 0.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b -> outputs stable, in_ready 0, no capture; out_ready=1 -> IDLE next edge.
REQ-038 Assert rst_n low during CALC at k=2 -> all outputs 0 asynchronously; after release, no out_valid; the next add 0x1234 + 0x1111 -> 0x2345.

Source files
------------

// File: rtl/cla_block_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_block_serial_adder
//   Block-serial adder/subtractor. An accepted operand pair is processed one
//   BLOCK-bit group per clock, low group first. Within a group the carries
//   come from a carry-look-ahead network seeded by the carry left by the
//   previous group. The result is held until the consumer takes it.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for operands (in_ready = 1), last result held
//   CALC  | processing group k, one group per rising edge
//   DONE  | result valid (out_valid = 1), held until out_ready
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands and mode present
//   in_ready   : block can accept operands
//   a, b       : N-bit operands
//   cin        : carry-in (add) / borrow-in (sub)
//   sub        : 0 = a+b+cin, 1 = a-b-cin
//   out_valid  : result valid
//   out_ready  : consumer accepts result
//   sum        : N-bit registered result
//   cout       : carry out of MSB (sub: 1 = no borrow)
//   overflow   : two's-complement signed overflow
//   zero       : sum == 0
// ---------------------------------------------------------------------------
module cla_block_serial_adder #(
    parameter int N     = 16,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);

    localparam int NB = N / BLOCK;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    a_reg, b_reg;
    logic            carry;
    logic [KW-1:0]   k;

    logic [BLOCK-1:0] grp_a, grp_b, grp_g, grp_p, grp_s;
    logic [BLOCK:0]   grp_c;
    logic             cl_acc, cl_term;
    logic [N-1:0]     grp_mask, sum_nxt;
    int               shamt;
    logic             accept, last_grp;

    // in_ready is gated by rst_n so it reads 0 while reset is held
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_grp  = (k == KW'(NB - 1));

    assign shamt = int'(k) * BLOCK;
    assign grp_a = BLOCK'(a_reg >> shamt);
    assign grp_b = BLOCK'(b_reg >> shamt);
    assign grp_g = grp_a & grp_b;
    assign grp_p = grp_a ^ grp_b;

    // Look-ahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0],
    // each carry formed directly from g/p and the group carry-in.
    always_comb begin
        grp_c    = '0;
        cl_acc   = 1'b0;
        cl_term  = 1'b0;
        grp_c[0] = carry;
        for (int i = 0; i < BLOCK; i++) begin
            cl_acc = carry;
            for (int j = 0; j <= i; j++)
                cl_acc = cl_acc & grp_p[j];
            for (int j = 0; j <= i; j++) begin
                cl_term = grp_g[j];
                for (int m = j + 1; m <= i; m++)
                    cl_term = cl_term & grp_p[m];
                cl_acc = cl_acc | cl_term;
            end
            grp_c[i+1] = cl_acc;
        end
    end

    assign grp_s    = grp_p ^ grp_c[BLOCK-1:0];
    assign grp_mask = N'({BLOCK{1'b1}}) << shamt;
    assign sum_nxt  = (sum & ~grp_mask) | (N'(grp_s) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last_grp)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            k        <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // subtraction as a + ~b + ~borrow_in
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        k     <= '0;
                    end
                end
                CALC: begin
                    sum   <= sum_nxt;
                    carry <= grp_c[BLOCK];
                    k     <= k + KW'(1);
                    if (last_grp) begin
                        cout     <= grp_c[BLOCK];
                        overflow <= grp_c[BLOCK] ^ grp_c[BLOCK-1];
                        zero     <= (sum_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_block_serial_adder.sv
module tb_cla_block_serial_adder;

    localparam int N = 16;
    localparam int BLOCK = 4;
    localparam int LAT = N / BLOCK + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [N-1:0]  a, b;
    logic          cin, sub;
    logic          out_valid, out_ready;
    logic [N-1:0]  sum;
    logic          cout, overflow, zero;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    cla_block_serial_adder #(.N(N), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic ci, input logic s);
        exp_t e;
        logic [N:0] full;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
            e.s  = full[N-1:0];
            e.c  = full[N];
            e.v  = (x[N-1] == y[N-1]) && (e.s[N-1] != x[N-1]);
        end else begin
            e.s  = x - y - N'(ci);
            e.c  = ({1'b0, x} >= ({1'b0, y} + (N+1)'(ci)));
            e.v  = (x[N-1] != y[N-1]) && (e.s[N-1] != x[N-1]);
        end
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic ci, input logic s, input int hold);
        exp_t e;
        int   edges;
        q.push_back(model(x, y, ci, s));
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
        @(posedge clk); #1;
        // scramble inputs after accept: captured operands must not follow
        in_valid = 1'b0; a = N'($urandom); b = N'($urandom); cin = ~ci; sub = ~s;
        chk("in_ready_calc", in_ready, 0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges + 1, LAT);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("overflow", overflow, e.v);
        chk("zero", zero, e.z);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = N'($urandom); b = N'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, e.s);
            chk("hold_flags", {cout, overflow, zero}, {e.c, e.v, e.z});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = N'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_no_capture", in_ready, 1);
        chk("idle_sum_held", sum, e.s);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, overflow, zero}, 3'b000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 3);

        // reset in CALC with k = 2
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_flags", {cout, overflow, zero}, 3'b000);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("no_valid_after_rst", seen, 0);
        chk("in_ready_after_rst", in_ready, 1);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++)
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), i % 2);

        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
